// File: rtl/serial_cmp_pkg.sv
// Shared types for the serial magnitude comparator: FSM states, result
// encoding and the default operand width.
package serial_cmp_pkg;

    localparam int unsigned WidthDefault = 8;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRunEq = 2'b01,
        StRunLt = 2'b10,
        StRunGt = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        ResEq = 2'b00,
        ResLt = 2'b01,
        ResGt = 2'b10
    } result_e;

    // Relation carried by a RUN_* state; IDLE never reaches here with a frame open.
    function automatic result_e state_to_result(input state_e st);
        result_e res;
        case (st)
            StRunLt: res = ResLt;
            StRunGt: res = ResGt;
            default: res = ResEq;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/serial_cmp_bitcnt.sv
// Saturating count of accepted bits in the current frame. clear wins over inc
// so the closing bit of a frame leaves the counter at zero for the next one.
module serial_cmp_bitcnt
    import serial_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = WidthDefault
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic                         inc,
    output logic [$clog2(WIDTH+2)-1:0]   count
);

    localparam int unsigned CntW = $clog2(WIDTH + 2);
    localparam logic [CntW-1:0] SatVal = CntW'(WIDTH + 1);

    logic [CntW-1:0] count_q, count_d;

    // Next count: clear, else increment until the WIDTH+1 ceiling.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != SatVal)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator of two WIDTH-bit operands.
// Default build is MSB-first (first differing bit decides). Defining
// SERIAL_CMP_LSB_FIRST_EN switches to LSB-first (last differing bit decides).
module serial_mag_comparator
    import serial_cmp_pkg::*;
#(
    parameter int unsigned WIDTH = WidthDefault
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in_last,
    input  logic a,
    input  logic b,
    output logic out_valid,
    output logic equal,
    output logic lesser,
    output logic greater,
    output logic frame_err,
    output logic busy
);

`ifdef SERIAL_CMP_LSB_FIRST_EN
    localparam bit LsbFirst = 1'b1;
`else
    localparam bit LsbFirst = 1'b0;
`endif

    localparam int unsigned CntW = $clog2(WIDTH + 2);

    state_e          state_q, state_d;
    state_e          base_state, decided;
    logic [CntW-1:0] count;
    logic [CntW:0]   count_incl;
    logic            frame_done;
    logic            out_valid_q;
    logic            res_valid_q;
    result_e         res_q;
    logic            frame_err_q;

    serial_cmp_bitcnt #(
        .WIDTH (WIDTH)
    ) u_bitcnt (
        .clk   (clk),
        .rst   (rst),
        .clear (frame_done),
        .inc   (in_valid),
        .count (count)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: fold the current bit pair into the relation decided so far.
    always_comb begin
        // A bit accepted in IDLE opens a frame with no relation decided yet.
        base_state = (state_q == StIdle) ? StRunEq : state_q;
        decided    = base_state;
        if ((a != b) && (LsbFirst || (base_state == StRunEq))) begin
            decided = a ? StRunGt : StRunLt;
        end
        state_d = state_q;
        if (in_valid) begin
            state_d = in_last ? StIdle : decided;
        end
    end

    // Combinational outputs: frame-close strobe, busy and the result decode.
    always_comb begin
        frame_done = in_valid && in_last;
        count_incl = {1'b0, count} + (CntW + 1)'(1);
        busy       = (state_q != StIdle);
        equal      = 1'b0;
        lesser     = 1'b0;
        greater    = 1'b0;
        if (res_valid_q) begin
            unique case (res_q)
                ResEq:   equal   = 1'b1;
                ResLt:   lesser  = 1'b1;
                ResGt:   greater = 1'b1;
                default: ;
            endcase
        end
    end

    // Result registers: captured on the closing bit, held until the next close.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_q       <= ResEq;
            frame_err_q <= 1'b0;
        end else begin
            out_valid_q <= frame_done;
            if (frame_done) begin
                res_valid_q <= 1'b1;
                res_q       <= state_to_result(decided);
                frame_err_q <= (count_incl != (CntW + 1)'(WIDTH));
            end
        end
    end

    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Bench for serial_mag_comparator (WIDTH=8). Honours SERIAL_CMP_LSB_FIRST_EN
// for bit ordering.
module tb_serial_mag_comparator;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic in_last = 1'b0;
    logic a = 1'b0;
    logic b = 1'b0;
    logic out_valid, equal, lesser, greater, frame_err, busy;

    int n_cmp = 0;
    int n_err = 0;

    serial_mag_comparator #(
        .WIDTH (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .equal     (equal),
        .lesser    (lesser),
        .greater   (greater),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: collect bit pairs, compare the assembled integers at frame end.
    bit    abits[$];
    bit    bbits[$];
    logic  m_ov, m_eq, m_lt, m_gt, m_err, m_busy;
    logic  mon_en = 1'b0;
    logic  sv, sl, sa, sb, sr;
    longint va, vb;

    always @(posedge clk) begin
        sv = in_valid; sl = in_last; sa = a; sb = b; sr = rst;
        if (sr) begin
            mon_en = 1'b1;
            abits.delete();
            bbits.delete();
            m_ov = 0; m_eq = 0; m_lt = 0; m_gt = 0; m_err = 0;
        end else begin
            m_ov = 0;
            if (sv) begin
                abits.push_back(sa);
                bbits.push_back(sb);
                if (sl) begin
                    va = 0;
                    vb = 0;
                    for (int i = 0; i < abits.size(); i++) begin
`ifdef SERIAL_CMP_LSB_FIRST_EN
                        va = va | (longint'(abits[i]) << i);
                        vb = vb | (longint'(bbits[i]) << i);
`else
                        va = (va << 1) | longint'(abits[i]);
                        vb = (vb << 1) | longint'(bbits[i]);
`endif
                    end
                    m_ov  = 1;
                    m_eq  = (va == vb);
                    m_lt  = (va < vb);
                    m_gt  = (va > vb);
                    m_err = (abits.size() != W);
                    abits.delete();
                    bbits.delete();
                end
            end
        end
        m_busy = (abits.size() != 0);
        #1;
        if (mon_en) begin
            check("out_valid", out_valid, m_ov);
            check("equal", equal, m_eq);
            check("lesser", lesser, m_lt);
            check("greater", greater, m_gt);
            check("frame_err", frame_err, m_err);
            check("busy", busy, m_busy);
        end
    end

    task automatic drive(input logic v, input logic l, input logic ai, input logic bi);
        @(negedge clk);
        in_valid = v;
        in_last  = l;
        a        = ai;
        b        = bi;
    endtask

    task automatic send_frame(input logic [31:0] av, input logic [31:0] bv, input int n,
                              input int gap_pct);
        logic [31:0] ta, tb;
        ta = av;
        tb = bv;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct) begin
                drive(1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            end
`ifdef SERIAL_CMP_LSB_FIRST_EN
            drive(1'b1, i == n - 1, ta[i], tb[i]);
`else
            drive(1'b1, i == n - 1, ta[n-1-i], tb[n-1-i]);
`endif
        end
    endtask

    // Idle one cycle, then check {out_valid, equal, lesser, greater, frame_err}.
    task automatic post_chk(input string tag, input logic [4:0] exp);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        check(tag, {out_valid, equal, lesser, greater, frame_err}, exp);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("reset_state", {out_valid, equal, lesser, greater, frame_err, busy}, 6'b0);
        rst = 1'b0;

        send_frame(32'hA5, 32'hA5, 8, 0);
        post_chk("a5_equal", 5'b11000);

        send_frame(32'h3C, 32'h3D, 8, 0);
        send_frame(32'h80, 32'h7F, 8, 0);
        post_chk("b2b_greater", 5'b10010);

        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                repeat (3) drive(1'b0, 1'b1, 1'b1, 1'b0);
            end
`ifdef SERIAL_CMP_LSB_FIRST_EN
            drive(1'b1, i == 7, 1'((8'h0F >> i) & 1), 1'((8'h10 >> i) & 1));
`else
            drive(1'b1, i == 7, 1'((8'h0F >> (7 - i)) & 1), 1'((8'h10 >> (7 - i)) & 1));
`endif
        end
        post_chk("gap_lesser", 5'b10100);

        send_frame(32'b10110, 32'b10100, 5, 0);
        post_chk("short_err", 5'b10011);
        send_frame(32'h1FF, 32'h1FF, 9, 0);
        post_chk("long_err", 5'b11001);
        send_frame(32'h1, 32'h0, 1, 0);
        post_chk("one_bit", 5'b10011);

        for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b1;
        in_last = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        check("abort_quiet", {out_valid, equal, lesser, greater, frame_err, busy}, 6'b0);
        send_frame(32'h00, 32'h00, 8, 0);
        post_chk("after_abort", 5'b11000);

        send_frame(32'h81, 32'h01, 8, 0);
        post_chk("msb_lsb_gt", 5'b10010);

        for (int f = 0; f < 200; f++) begin
            int n;
            n = ($urandom_range(3) == 0) ? int'($urandom_range(1, 11)) : int'(W);
            if ($urandom_range(19) == 0) begin
                send_frame($urandom, $urandom, int'($urandom_range(1, 6)), 20);
                drive(1'b0, 1'b0, 1'b0, 1'b0);
                rst = 1'b1;
                in_valid = 1'($urandom);
                @(negedge clk);
                rst = 1'b0;
                in_valid = 1'b0;
            end else begin
                send_frame($urandom, ($urandom_range(3) == 0) ? 32'h0 : $urandom, n,
                           int'($urandom_range(0, 1)) * 30);
                repeat ($urandom_range(2)) drive(1'b0, 1'b0, 1'b0, 1'b0);
            end
        end

        repeat (3) drive(1'b0, 1'b0, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
